// File: rtl/led_cmd_rx.sv
// led_cmd_rx: UART (8N1) command receiver and decoder for the PWM LED fader.
// Frames are A5 <addr> <data> <addr^data>. Valid frames write one fader
// configuration register; bad frames raise a one-cycle frame_err.
// Optional acknowledge transmitter on uart_tx is enabled by LED_CMD_ACK_EN
// (0x06 after a commit, 0x15 after a rejected frame).
module led_cmd_rx #(
   parameter int CLK_FREQ     = 25_000_000,
   parameter int BAUD         = 115_200,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] led_mask,
   output logic [7:0] bright_max,
   output logic [7:0] fade_div,
   output logic [1:0] mode,
   output logic       cfg_update,
   output logic       frame_err,
   output logic       uart_tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int BIT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W         = $clog2(TO_LIMIT + 1);

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_START = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;
   localparam logic [1:0] R_STOP  = 2'd3;

   localparam logic [1:0] P_HDR  = 2'd0;
   localparam logic [1:0] P_ADDR = 2'd1;
   localparam logic [1:0] P_DATA = 2'd2;
   localparam logic [1:0] P_CHK  = 2'd3;

   logic             rx_meta_r;
   logic             rx_sync_r;
   logic [1:0]       rx_state_r;
   logic [BIT_W-1:0] bit_cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic             byte_valid_r;
   logic             stop_err_r;

   logic [1:0]       p_state_r;
   logic [7:0]       addr_r;
   logic [7:0]       data_r;
   logic [TO_W-1:0]  gap_cnt_r;
   logic             pend_commit_r;
   logic             pend_reject_r;
   logic             frame_ok_s;

   // Two-flop synchroniser for the asynchronous serial input (idles high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= uart_rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Receive FSM: start-bit qualification at half a bit, then mid-bit sampling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_r   <= R_IDLE;
         bit_cnt_r    <= '0;
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'h00;
         byte_valid_r <= 1'b0;
         stop_err_r   <= 1'b0;
      end else begin
         byte_valid_r <= 1'b0;
         stop_err_r   <= 1'b0;
         case (rx_state_r)
            R_IDLE: begin
               bit_cnt_r <= '0;
               bit_idx_r <= 3'd0;
               if (!rx_sync_r) rx_state_r <= R_START;
            end
            R_START: begin
               if (bit_cnt_r == BIT_W'(HALF_BIT - 1)) begin
                  bit_cnt_r  <= '0;
                  // A line already back high here was a glitch, not a start bit.
                  rx_state_r <= rx_sync_r ? R_IDLE : R_DATA;
               end else begin
                  bit_cnt_r <= bit_cnt_r + BIT_W'(1);
               end
            end
            R_DATA: begin
               if (bit_cnt_r == BIT_W'(CLKS_PER_BIT - 1)) begin
                  bit_cnt_r <= '0;
                  shift_r   <= {rx_sync_r, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
                  if (bit_idx_r == 3'd7) rx_state_r <= R_STOP;
               end else begin
                  bit_cnt_r <= bit_cnt_r + BIT_W'(1);
               end
            end
            R_STOP: begin
               if (bit_cnt_r == BIT_W'(CLKS_PER_BIT - 1)) begin
                  bit_cnt_r  <= '0;
                  rx_state_r <= R_IDLE;
                  if (rx_sync_r) byte_valid_r <= 1'b1;
                  else           stop_err_r   <= 1'b1;
               end else begin
                  bit_cnt_r <= bit_cnt_r + BIT_W'(1);
               end
            end
            default: rx_state_r <= R_IDLE;
         endcase
      end
   end

   // Frame acceptance: checksum matches, address exists, mode value legal.
   always_comb begin
      frame_ok_s = 1'b0;
      if ((shift_r == (addr_r ^ data_r)) && (addr_r <= 8'd3)) begin
         if ((addr_r == 8'd3) && (data_r > 8'd2)) frame_ok_s = 1'b0;
         else                                     frame_ok_s = 1'b1;
      end else begin
         frame_ok_s = 1'b0;
      end
   end

   // Parser FSM plus inter-byte timeout; the verdict is staged one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state_r     <= P_HDR;
         addr_r        <= 8'h00;
         data_r        <= 8'h00;
         gap_cnt_r     <= '0;
         pend_commit_r <= 1'b0;
         pend_reject_r <= 1'b0;
      end else begin
         pend_commit_r <= 1'b0;
         pend_reject_r <= 1'b0;
         if (stop_err_r) begin
            p_state_r <= P_HDR;
            gap_cnt_r <= '0;
         end else if (byte_valid_r) begin
            gap_cnt_r <= '0;
            case (p_state_r)
               P_HDR:  if (shift_r == 8'hA5) p_state_r <= P_ADDR;
               P_ADDR: begin
                  addr_r    <= shift_r;
                  p_state_r <= P_DATA;
               end
               P_DATA: begin
                  data_r    <= shift_r;
                  p_state_r <= P_CHK;
               end
               P_CHK: begin
                  p_state_r <= P_HDR;
                  if (frame_ok_s) pend_commit_r <= 1'b1;
                  else            pend_reject_r <= 1'b1;
               end
               default: p_state_r <= P_HDR;
            endcase
         end else if ((p_state_r != P_HDR) && (rx_state_r == R_IDLE)) begin
            if (gap_cnt_r == TO_W'(TO_LIMIT - 1)) begin
               p_state_r <= P_HDR;
               gap_cnt_r <= '0;
            end else begin
               gap_cnt_r <= gap_cnt_r + TO_W'(1);
            end
         end else begin
            gap_cnt_r <= '0;
         end
      end
   end

   // Configuration registers and the cfg_update / frame_err pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_mask   <= 8'h55;
         bright_max <= 8'hFF;
         fade_div   <= 8'd1;
         mode       <= 2'd0;
         cfg_update <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         cfg_update <= pend_commit_r;
         frame_err  <= pend_reject_r | stop_err_r;
         if (pend_commit_r) begin
            case (addr_r[1:0])
               2'd0:    led_mask   <= data_r;
               2'd1:    bright_max <= data_r;
               2'd2:    fade_div   <= (data_r == 8'd0) ? 8'd1 : data_r;
               2'd3:    mode       <= data_r[1:0];
               default: mode       <= mode;
            endcase
         end
      end
   end

`ifdef LED_CMD_ACK_EN
   logic             ack_rej_r;
   logic             tx_busy_r;
   logic [8:0]       tx_shift_r;
   logic [BIT_W-1:0] tx_cnt_r;
   logic [3:0]       tx_idx_r;

   // Marks rejected frames only; stop-bit errors are not acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack_rej_r <= 1'b0;
      else        ack_rej_r <= pend_reject_r;
   end

   // Acknowledge transmitter; events arriving while busy are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx    <= 1'b1;
         tx_busy_r  <= 1'b0;
         tx_shift_r <= 9'h1FF;
         tx_cnt_r   <= '0;
         tx_idx_r   <= 4'd0;
      end else if (!tx_busy_r) begin
         if (cfg_update || ack_rej_r) begin
            tx_busy_r  <= 1'b1;
            uart_tx    <= 1'b0;
            tx_shift_r <= {1'b1, (cfg_update ? 8'h06 : 8'h15)};
            tx_cnt_r   <= '0;
            tx_idx_r   <= 4'd0;
         end else begin
            uart_tx <= 1'b1;
         end
      end else if (tx_cnt_r == BIT_W'(CLKS_PER_BIT - 1)) begin
         tx_cnt_r <= '0;
         if (tx_idx_r == 4'd9) begin
            tx_busy_r <= 1'b0;
            uart_tx   <= 1'b1;
         end else begin
            uart_tx    <= tx_shift_r[0];
            tx_shift_r <= {1'b1, tx_shift_r[8:1]};
            tx_idx_r   <= tx_idx_r + 4'd1;
         end
      end else begin
         tx_cnt_r <= tx_cnt_r + BIT_W'(1);
      end
   end
`else
   assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_led_cmd_rx.sv
// Self-checking bench for led_cmd_rx. A frame-level model predicts the
// ordered stream of cfg_update / frame_err events and the register file;
// one compare process checks the DUT against it every clock.
module tb_led_cmd_rx;

   localparam int CPB = 10;   // 1 MHz clock / 100 kbaud

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic [7:0] led_mask, bright_max, fade_div;
   logic [1:0] mode;
   logic       cfg_update, frame_err, uart_tx;

   led_cmd_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .TIMEOUT_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
      .led_mask(led_mask), .bright_max(bright_max), .fade_div(fade_div),
      .mode(mode), .cfg_update(cfg_update), .frame_err(frame_err),
      .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 commit, 1 rejected frame, 2 stop-bit error
   typedef struct packed {
      logic [1:0] kind;
      logic [1:0] addr;
      logic [7:0] val;
   } ev_t;

   ev_t        ev_q[$];
   ev_t        cur_ev;
   logic [7:0] ack_q[$];
   logic [7:0] m_reg [4] = '{8'h55, 8'hFF, 8'h01, 8'h00};
   int         n_cmp = 0;
   int         n_bad = 0;
   int         last_cfg_cyc = 0;
   int         last_start_cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_reg = '{8'h55, 8'hFF, 8'h01, 8'h00};
      ev_q.delete();
      ack_q.delete();
   endtask

   // Spec-level verdict for one complete A5-headed frame.
   function automatic void judge(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      ev_t e;
      e.kind = 2'd1;
      e.addr = a[1:0];
      e.val  = d;
      if ((c == (a ^ d)) && (a <= 8'd3) && !((a == 8'd3) && (d > 8'd2))) begin
         e.kind = 2'd0;
         if ((a == 8'd2) && (d == 8'd0)) e.val = 8'd1;
      end
      ev_q.push_back(e);
   endfunction

   // Drives one 8N1 byte starting at a falling clock edge; ends on one too.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      last_start_cyc = cyc;
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      judge(a, d, c);
      send_byte(8'hA5, 1'b1);
      send_byte(a, 1'b1);
      send_byte(d, 1'b1);
      send_byte(c, 1'b1);
   endtask

   task automatic idle(input int bits);
      repeat (bits * CPB) @(negedge clk);
   endtask

   // Per-cycle comparison of pulses and registers against the model.
   initial forever begin
      @(posedge clk);
      #1;
      if (cfg_update && frame_err) begin
         check("pulse_overlap", {cfg_update, frame_err}, 32'd1);
      end else if (cfg_update || frame_err) begin
         if (ev_q.size() == 0) begin
            check("unexpected_pulse", {cfg_update, frame_err}, 32'd0);
         end else begin
            cur_ev = ev_q.pop_front();
            check("pulse_kind", {31'd0, cfg_update}, {31'd0, (cur_ev.kind == 2'd0)});
            if (cfg_update) begin
               m_reg[cur_ev.addr] = cur_ev.val;
               last_cfg_cyc = cyc;
               ack_q.push_back(8'h06);
            end else if (cur_ev.kind == 2'd1) begin
               ack_q.push_back(8'h15);
            end
         end
      end
      check("regs", {led_mask, bright_max, fade_div, 6'd0, mode},
            {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
`ifndef LED_CMD_ACK_EN
      check("uart_tx_idle", {31'd0, uart_tx}, 32'd1);
`endif
   end

`ifdef LED_CMD_ACK_EN
   logic [7:0] ack_byte;
   // Decodes acknowledge bytes on uart_tx and matches them in order.
   initial forever begin
      @(negedge uart_tx);
      repeat (CPB / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk);
         #1;
         ack_byte[i] = uart_tx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      check("ack_stop", {31'd0, uart_tx}, 32'd1);
      if (ack_q.size() == 0) check("ack_unexpected", 32'(ack_q.size()), 32'd1);
      else                   check("ack_byte", {24'd0, ack_byte}, {24'd0, ack_q.pop_front()});
   end
`endif

   initial begin
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("reset_led",    {24'd0, led_mask},   32'h55);
      check("reset_bright", {24'd0, bright_max}, 32'hFF);
      check("reset_fade",   {24'd0, fade_div},   32'h01);
      check("reset_mode",   {30'd0, mode},       32'd0);

      // Valid write; cfg_update lands 100 clocks after the checksum start bit:
      // 2 sync + 1 detect + 5 half-bit + 80 data + 10 stop-centre + 2 commit.
      send_frame(8'h00, 8'h0F, 8'h0F);
      idle(1);
      check("commit_latency", 32'(last_cfg_cyc - last_start_cyc), 32'd100);
      check("valid_led",    {24'd0, led_mask},   32'h0F);
      check("valid_bright", {24'd0, bright_max}, 32'hFF);

      // Bad checksum, illegal mode value, clamped fade divider.
      send_frame(8'h01, 8'h80, 8'h00);
      idle(1);
      check("badchk_bright", {24'd0, bright_max}, 32'hFF);
      send_frame(8'h03, 8'h03, 8'h00);
      idle(1);
      check("illegal_mode", {30'd0, mode}, 32'd0);
      send_frame(8'h02, 8'h00, 8'h02);
      idle(1);
      check("clamp_fade", {24'd0, fade_div}, 32'h01);
      send_frame(8'h04, 8'h11, 8'h15);   // address out of range
      idle(12);
      check("events_drained_1", 32'(ev_q.size()), 32'd0);

      // Timeout abandons the partial frame; the resent A5 is a header again.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      idle(40);
      send_frame(8'h01, 8'h40, 8'h41);
      idle(1);
      check("timeout_bright", {24'd0, bright_max}, 32'h40);

      // Short low glitch: neither a byte nor an error.
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      idle(12);

      // Four frames with zero idle between bytes.
      send_frame(8'h00, 8'h3C, 8'h3C);
      send_frame(8'h01, 8'h80, 8'h81);
      send_frame(8'h02, 8'h07, 8'h05);
      send_frame(8'h03, 8'h01, 8'h02);
      idle(12);
      check("b2b_led",    {24'd0, led_mask},   32'h3C);
      check("b2b_bright", {24'd0, bright_max}, 32'h80);
      check("b2b_fade",   {24'd0, fade_div},   32'h07);
      check("b2b_mode",   {30'd0, mode},       32'd1);

      // Stop bit forced low mid-frame; the following frame still decodes.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      ev_q.push_back('{kind: 2'd2, addr: 2'd0, val: 8'h00});
      send_byte(8'h5A, 1'b0);
      idle(2);
      send_frame(8'h02, 8'h09, 8'h0B);
      idle(12);
      check("after_stoperr_fade", {24'd0, fade_div}, 32'h09);
      check("after_stoperr_led",  {24'd0, led_mask}, 32'h3C);
      check("events_drained_2", 32'(ev_q.size()), 32'd0);

      // Reset in the middle of a byte, then a clean frame.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      uart_rx = 1'b0;
      repeat (4 * CPB) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset_led",    {24'd0, led_mask},   32'h55);
      check("midreset_bright", {24'd0, bright_max}, 32'hFF);
      check("midreset_fade",   {24'd0, fade_div},   32'h01);
      check("midreset_mode",   {30'd0, mode},       32'd0);
      check("midreset_tx",     {31'd0, uart_tx},    32'd1);
      rst_n = 1'b1;
      idle(2);
      send_frame(8'h00, 8'hAA, 8'hAA);
      idle(12);
      check("post_reset_led", {24'd0, led_mask}, 32'hAA);
      check("events_drained_3", 32'(ev_q.size()), 32'd0);
`ifdef LED_CMD_ACK_EN
      check("acks_drained", 32'(ack_q.size()), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_cmd_rx.md
Name: led_cmd_rx

Overview:
- UART command receiver and decoder that sits directly upstream of the PWM LED fader.
- Deserialises 8N1 bytes from a host pin and parses 4-byte command frames.
- Drives the fader's configuration registers: LED group mask, brightness ceiling, fade divider, mode.
- Gives the blink stage remote control.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 217 at defaults).
- TIMEOUT_BITS, 32, inter-byte gap (in bit periods) after which a partial frame is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, idle high, asynchronous to clk.
- led_mask  out  8  LED group-A mask for the fader.
- bright_max  out  8  brightness ceiling (PWM compare limit).
- fade_div  out  8  fade interval in ms per step; never 0.
- mode  out  2  0 = fade, 1 = static on, 2 = all off.
- cfg_update  out  1  one-cycle pulse when any register is written.
- frame_err  out  1  one-cycle pulse on a rejected frame or a bad stop bit.
- uart_tx  out  1  acknowledge serial output (see Optional Feature).

Behaviour:
- Reset values, asynchronous on rst_n low:
  - led_mask = 8'h55, bright_max = 8'hFF, fade_div = 8'd1, mode = 2'd0.
  - cfg_update = 0, frame_err = 0, uart_tx = 1.
  - Both FSMs return to their idle states; all counters cleared.
- Input synchronisation: uart_rx passes through a 2-FF synchroniser. All references to rx below mean the synchronised signal.
- RX FSM:
  - R_IDLE: wait for rx = 0.
  - R_START: count CLKS_PER_BIT/2. If rx is still 0, go to R_DATA. Otherwise it was a glitch; return to R_IDLE with no error.
  - R_DATA: sample 8 bits, LSB first, at intervals of CLKS_PER_BIT.
  - R_STOP: sample at mid stop bit. If rx = 1, byte_valid pulses on the next edge. If rx = 0, pulse frame_err, reset the parser to P_HDR, and discard the byte.
  - After R_STOP, return to R_IDLE.
- Parser FSM, advanced by byte_valid:
  - P_HDR: accept 0xA5 and go to P_ADDR. Any other byte is ignored silently.
  - P_ADDR: store addr, go to P_DATA.
  - P_DATA: store data, go to P_CHK.
  - P_CHK: compare the byte with addr ^ data, then always return to P_HDR.
- Commit on valid checksum with a legal address:
  - 0x00 writes led_mask.
  - 0x01 writes bright_max.
  - 0x02 writes fade_div; data 0 is clamped to 1.
  - 0x03 writes mode; data > 2 is illegal.
- Rejection: bad checksum, addr > 3, or illegal mode data gives a frame_err pulse and no register change.
- Commit timing: the register and the cfg_update pulse change on the same edge, exactly one cycle after byte_valid. That is 2 clk edges after the checksum stop-bit sample.
- cfg_update and frame_err are never asserted together and never exceed 1 cycle.
- Timeout: a gap counter runs while the parser is not in P_HDR and the RX FSM is in R_IDLE. When it reaches TIMEOUT_BITS*CLKS_PER_BIT, the parser returns to P_HDR silently (no frame_err). Any start bit clears the counter.
- Back-to-back bytes: the stop bit is followed immediately by the next start with no idle time, and no byte is lost.
- An 0xA5 arriving in P_ADDR, P_DATA or P_CHK is treated as data, not as a resync.
- Reset mid-frame: the partial frame is discarded and no output changes except the return to reset values.
- Counter widths: bit-timing counter sized by $clog2(CLKS_PER_BIT+1); timeout counter sized by $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1).

Optional Feature:
- Macro: LED_CMD_ACK_EN.
- When defined:
  - An 8N1 transmitter at BAUD drives uart_tx.
  - It sends 0x06 after each commit and 0x15 after each rejected frame (not after stop-bit errors).
  - Transmission starts the cycle after cfg_update or frame_err.
  - An event arriving while a transmission is busy is dropped; it is not queued.
- When undefined: uart_tx is tied to 1 and no TX logic is synthesised.

Test Plan:
- Reset: assert rst_n = 0 mid-byte → outputs read 0x55 / 0xFF / 0x01 / 0 and uart_tx = 1. After release, a clean frame is accepted.
- Valid write: send A5 00 0F 0F → led_mask = 0x0F. A single cfg_update pulse arrives 2 edges after the final stop sample. Other registers are unchanged.
- Bad checksum: send A5 01 80 00 → frame_err pulses once and bright_max stays 0xFF.
- Illegal values: send A5 03 03 00 → frame_err pulses and mode stays 0. Then send A5 02 00 02 → fade_div = 1 (clamped) and cfg_update pulses.
- Timeout and noise: send A5 01, wait 40 bit periods, then send A5 01 40 41 → bright_max = 0x40 only. Separately, a 3-cycle low glitch on uart_rx → no byte and no error.
- Back-to-back framing: four frames sent with zero idle → all four commit. A stop bit forced to 0 → frame_err pulses and the next frame is still decoded. With LED_CMD_ACK_EN defined, the 0x06 / 0x15 bytes appear on uart_tx.
